// File: rtl/packet_link_scheduler.sv
// Round-robin, packet-granular scheduler that shares one credit-flow-controlled
// NIC link among several flit FIFOs (virtual channels).
module packet_link_scheduler #(
    parameter int unsigned N_REQUEST_SIGNAL = 6,
    parameter int unsigned N_BITS_POINTER   = (N_REQUEST_SIGNAL > 1) ? $clog2(N_REQUEST_SIGNAL) : 1,
    parameter int unsigned N_CREDITS        = 4,
    parameter int unsigned N_BITS_CREDIT    = $clog2(N_CREDITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQUEST_SIGNAL-1:0] r_la_i,
    input  logic [N_REQUEST_SIGNAL-1:0] tail_i,
    input  logic                        credit_i,
    output logic                        g_valid_o,
    output logic [N_BITS_POINTER-1:0]   g_channel_id_o,
    output logic [N_REQUEST_SIGNAL-1:0] g_onehot_o,
    output logic                        busy_o,
    output logic [N_BITS_CREDIT-1:0]    credits_o,
    output logic                        credit_err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [N_BITS_POINTER-1:0] LAST_RST  = N_BITS_POINTER'(N_REQUEST_SIGNAL - 1);
    localparam logic [N_BITS_CREDIT-1:0]  CRED_FULL = N_BITS_CREDIT'(N_CREDITS);
    localparam logic [N_REQUEST_SIGNAL-1:0] ONE_HOT_0 = N_REQUEST_SIGNAL'(1);

    state_e                      state_q, state_d;
    logic [N_BITS_POINTER-1:0]   owner_q, owner_d;
    logic [N_BITS_POINTER-1:0]   last_q, last_d;
    logic [N_BITS_CREDIT-1:0]    credits_q, credits_d;
    logic                        credit_err_q, credit_err_d;

    logic                        win_found;
    logic [N_BITS_POINTER-1:0]   win_id;
    logic [N_BITS_POINTER-1:0]   idx;
    int unsigned                 sum;
    logic                        credit_ok;
    logic                        valid;
    logic [N_BITS_POINTER-1:0]   sel_id;

    // Circular search starting one past the most recent winner; wrap handled explicitly
    // so non-power-of-two channel counts never index past N-1.
    always_comb begin
        win_found = 1'b0;
        win_id    = last_q;
        sum       = 0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_REQUEST_SIGNAL; k++) begin
            sum = 32'(last_q) + k;
            if (sum >= N_REQUEST_SIGNAL) begin
                sum = sum - N_REQUEST_SIGNAL;
            end
            idx = N_BITS_POINTER'(sum);
            if (!win_found && r_la_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign credit_ok = (credits_q != '0);

    // Next-state and grant decode
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        valid   = 1'b0;
        sel_id  = last_q;
        case (state_q)
            IDLE: begin
                sel_id = win_found ? win_id : last_q;
                valid  = win_found && credit_ok;
                if (valid) begin
                    last_d = win_id;
                    if (!tail_i[win_id]) begin
                        state_d = LOCKED;
                        owner_d = win_id;
                    end
                end
            end
            LOCKED: begin
                sel_id = owner_q;
                valid  = r_la_i[owner_q] && credit_ok;
                if (valid && tail_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            valid  = 1'b0;
            sel_id = '0;
        end
    end

    // Credit accounting: send and return in one cycle cancel out
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        case ({valid, credit_i})
            2'b10: credits_d = credits_q - N_BITS_CREDIT'(1);
            2'b01: begin
                if (credits_q == CRED_FULL) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + N_BITS_CREDIT'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_q       <= LAST_RST;
            credits_q    <= CRED_FULL;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign g_valid_o      = valid;
    assign g_channel_id_o = sel_id;
    assign g_onehot_o     = valid ? (ONE_HOT_0 << sel_id) : '0;
    assign busy_o         = (state_q == LOCKED);
    assign credits_o      = credits_q;
    assign credit_err_o   = credit_err_q;

endmodule

// File: tb/tb_packet_link_scheduler.sv
// Directed bench for packet_link_scheduler: reset, round-robin wrap, packet lock,
// credit stall/return, credit overflow and mid-packet reset.
module tb_packet_link_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] r_la_i;
    logic [5:0] tail_i;
    logic       credit_i;
    logic       g_valid_o;
    logic [2:0] g_channel_id_o;
    logic [5:0] g_onehot_o;
    logic       busy_o;
    logic [2:0] credits_o;
    logic       credit_err_o;

    int errors = 0;
    int checks = 0;

    packet_link_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .r_la_i         (r_la_i),
        .tail_i         (tail_i),
        .credit_i       (credit_i),
        .g_valid_o      (g_valid_o),
        .g_channel_id_o (g_channel_id_o),
        .g_onehot_o     (g_onehot_o),
        .busy_o         (busy_o),
        .credits_o      (credits_o),
        .credit_err_o   (credit_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant check: valid, id (when valid) and the one-hot strobe it implies.
    task automatic chk_grant(input string tag, input logic v, input logic [2:0] id);
        logic [5:0] oh;
        oh = v ? (6'b000001 << id) : 6'b000000;
        chk({tag, ".valid"}, 32'(g_valid_o), 32'(v));
        if (v) chk({tag, ".id"}, 32'(g_channel_id_o), 32'(id));
        chk({tag, ".onehot"}, 32'(g_onehot_o), 32'(oh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [2:0] rr_ids [5];
        rr_ids = '{3'd2, 3'd5, 3'd0, 3'd2, 3'd5};

        // Reset with every channel requesting
        rst = 1'b1; r_la_i = 6'b111111; tail_i = 6'b111111; credit_i = 1'b0;
        tick(); tick();
        chk_grant("rst", 1'b0, 3'd0);
        chk("rst.id", 32'(g_channel_id_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.credits", 32'(credits_o), 32'd4);
        chk("rst.err", 32'(credit_err_o), 32'd0);

        rst = 1'b0; credit_i = 1'b1; settle();
        chk_grant("first", 1'b1, 3'd0);
        tick();

        // Round-robin over 100101 with wrap, last=0 so sequence starts at 2
        r_la_i = 6'b100101;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk_grant($sformatf("rr%0d", i), 1'b1, rr_ids[i]);
            chk($sformatf("rr%0d.credits", i), 32'(credits_o), 32'd4);
            tick();
        end
        r_la_i = 6'b100001; settle();
        chk_grant("rr_wrap", 1'b1, 3'd0);
        tick();
        r_la_i = 6'b100000; settle();
        chk_grant("rr_to5", 1'b1, 3'd5);
        tick();

        // Three-flit packet on FIFO 0 with a bubble, FIFO 1 must wait
        r_la_i = 6'b000011; tail_i = 6'b000000; settle();
        chk_grant("lock.f1", 1'b1, 3'd0);
        chk("lock.f1.busy", 32'(busy_o), 32'd0);
        tick();
        settle();
        chk_grant("lock.f2", 1'b1, 3'd0);
        chk("lock.f2.busy", 32'(busy_o), 32'd1);
        tick();
        r_la_i = 6'b000010; credit_i = 1'b0; settle();
        chk_grant("lock.bubble", 1'b0, 3'd0);
        chk("lock.bubble.busy", 32'(busy_o), 32'd1);
        tick();
        r_la_i = 6'b000011; tail_i = 6'b000001; credit_i = 1'b1; settle();
        chk_grant("lock.f3", 1'b1, 3'd0);
        chk("lock.f3.busy", 32'(busy_o), 32'd1);
        tick();
        tail_i = 6'b111111; settle();
        chk("lock.after.busy", 32'(busy_o), 32'd0);
        chk_grant("lock.next", 1'b1, 3'd1);
        chk("lock.credits", 32'(credits_o), 32'd4);
        tick();

        // Credit stall with no returns
        r_la_i = 6'b000001; credit_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("stall%0d.credits", i), 32'(credits_o), 32'(4 - i));
            chk_grant($sformatf("stall%0d", i), 1'b1, 3'd0);
            tick();
        end
        settle();
        chk("stall.credits0", 32'(credits_o), 32'd0);
        chk_grant("stall.blocked", 1'b0, 3'd0);
        credit_i = 1'b1; settle();
        chk_grant("stall.ret_cycle", 1'b0, 3'd0);
        tick();
        credit_i = 1'b0; settle();
        chk("stall.credits1", 32'(credits_o), 32'd1);
        chk_grant("stall.one", 1'b1, 3'd0);
        tick();
        settle();
        chk("stall.again.credits", 32'(credits_o), 32'd0);
        chk_grant("stall.again", 1'b0, 3'd0);

        // Refill to 2, then send and return in the same cycle
        r_la_i = 6'b000000; credit_i = 1'b1;
        tick(); tick();
        chk("simul.pre", 32'(credits_o), 32'd2);
        r_la_i = 6'b000001; settle();
        chk_grant("simul", 1'b1, 3'd0);
        tick();
        chk("simul.post", 32'(credits_o), 32'd2);

        // Overflow sets the sticky error
        r_la_i = 6'b000000;
        tick(); tick();
        chk("ovf.full", 32'(credits_o), 32'd4);
        chk("ovf.err_clear", 32'(credit_err_o), 32'd0);
        tick();
        chk("ovf.credits", 32'(credits_o), 32'd4);
        chk("ovf.err", 32'(credit_err_o), 32'd1);
        credit_i = 1'b0;
        tick();
        chk("ovf.sticky", 32'(credit_err_o), 32'd1);

        // Reset in the middle of a 3-flit packet on FIFO 1
        r_la_i = 6'b000010; tail_i = 6'b000000; settle();
        chk_grant("mid.f1", 1'b1, 3'd1);
        tick();
        settle();
        chk_grant("mid.f2", 1'b1, 3'd1);
        tick();
        chk("mid.busy", 32'(busy_o), 32'd1);
        chk("mid.credits", 32'(credits_o), 32'd2);
        rst = 1'b1; settle();
        chk_grant("mid.rst", 1'b0, 3'd0);
        chk("mid.rst.id", 32'(g_channel_id_o), 32'd0);
        tick();
        rst = 1'b0; r_la_i = 6'b111111; tail_i = 6'b111111; settle();
        chk("mid.post.busy", 32'(busy_o), 32'd0);
        chk("mid.post.credits", 32'(credits_o), 32'd4);
        chk("mid.post.err", 32'(credit_err_o), 32'd0);
        chk_grant("mid.post.grant", 1'b1, 3'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
